sd_spi_arbiter: RTL and testbench
=================================

# sd_spi_arbiter

Shares the SD-card SPI path between two SPI masters (requester 0: DivMMC SPI from the zx48 core; requester 1: a secondary loader/utility master) and steers the granted master to either the virtual SD card (sd_card over HPS) or the physical SD pins. It owns the virtual/physical select, which updates only when the bus is idle. It also generates the SD activity indication for the LEDs. It sits in the top level between the core/loader SPI ports and the sd_card instance and SD_* pins.

## Interface
Parameters:
- ACT_TIMEOUT, 1000000: clock cycles after the last MOSI/MISO edge during which activity stays asserted.
- GUARD, 4: minimum idle cycles with all chip selects high between two grants.

Ports:
- clock  in  1  system clock (clk_sys, 56 MHz).
- reset  in  1  asynchronous, active-low reset.
- img_mounted  in  1  single-cycle pulse: image mount state changed.
- img_present  in  1  image size non-zero, sampled on img_mounted.
- m0_req, m1_req  in  1  bus request, level.
- m0_gnt, m1_gnt  out  1  bus grant, registered.
- m0_ck, m1_ck  in  1  SPI clock from master.
- m0_cs, m1_cs  in  1  SPI chip select, active-low.
- m0_mosi, m1_mosi  in  1  SPI data from master.
- m0_miso, m1_miso  out  1  SPI data to master; 1 when not granted.
- vsd_ck, vsd_ss, vsd_mosi  out  1 each  to sd_card.
- vsd_miso  in  1  from sd_card.
- sd_ck, sd_cs, sd_mosi  out  1 each  to physical card.
- sd_miso  in  1  from physical card.
- vsd_sel  out  1  1 = virtual card is the target.
- act_vsd, act_sd  out  1  activity flags, split by target.
- busy  out  1  a grant is active or a release is in progress.

## Operation
- States: IDLE, GNT0, GNT1, RELEASE.
- IDLE: no grant. If exactly one req is high, grant that master. If both are high, use round-robin: the master not granted last wins. The last-grant pointer resets to 1, so m0 wins the first tie.
- GNTn → RELEASE when mn_req = 0 and mn_cs = 1. If req drops while cs = 0, the grant is held until cs rises.
- RELEASE: counts GUARD cycles, then returns to IDLE. Requests are ignored until IDLE.
- Mux: the granted master's ck/cs/mosi drive the selected target. The unselected target and the ungranted state are driven idle: ck = 0, cs/ss = 1, mosi = 1. Target miso is routed to the granted master only.
- vsd_sel: on img_mounted, pending_sel ← img_present. pending_sel is copied to vsd_sel only in IDLE. A mount pulse during a grant takes effect on the first IDLE cycle after release. A later pulse overwrites pending_sel.
- Activity: the block registers the previous mosi/miso of the active path. Any change resets the counter to 0. Otherwise the counter increments, saturating at ACT_TIMEOUT. act = counter < ACT_TIMEOUT; act_vsd = act & vsd_sel; act_sd = act & ~vsd_sel. Counter width is $clog2(ACT_TIMEOUT+1).

## Timing
- Reset values: state IDLE, gnt = 0, busy = 0, vsd_sel = 0, pending_sel = 0, counter = ACT_TIMEOUT (act = 0), all SPI outputs idle, miso outputs = 1.
- Grant latency: req sampled high in IDLE → gnt high on the next clock edge.
- SPI path: combinational from the master inputs through a mux selected by registered grant and vsd_sel. No added latency and no SPI resampling.
- Release latency: release condition at cycle t → RELEASE at t+1 (gnt low) → IDLE at t+1+GUARD.
- vsd_sel changes only on a cycle where state is IDLE and gnt is 0. It never changes while any target cs is low.
- Reset mid-transfer: all outputs return to idle values immediately (asynchronous). The transfer is aborted.

## Configuration
- SD_ARB_ACTIVITY_EN defined: activity counter is compiled in, and act_vsd/act_sd behave as above.
- SD_ARB_ACTIVITY_EN undefined: no counter logic; act_vsd and act_sd are tied 0; all other behaviour is unchanged.

## Structure
- Package sd_arb_pkg: state enum (IDLE, GNT0, GNT1, RELEASE), SPI idle-level constants (CK_IDLE = 0, CS_IDLE = 1, MOSI_IDLE = 1).
- Sub-module sd_activity_timer: edge detect plus saturating counter, parameterised by ACT_TIMEOUT. It is instantiated only under SD_ARB_ACTIVITY_EN.

## Test plan
- Reset, then m0_req = 1 → m0_gnt = 1 one cycle later. m0_ck/cs/mosi appear on sd_*, vsd_* stay idle, and m1_miso = 1.
- m0_req and m1_req rise on the same cycle after reset → m0 is granted. After m0 releases, m1 is granted GUARD+1 cycles after m0_gnt falls (5 cycles with GUARD = 4).
- Hold m0_cs = 0 and drop m0_req → m0_gnt stays 1 until m0_cs = 1, then falls the next cycle.
- During a m0 grant, pulse img_mounted with img_present = 1 → vsd_sel stays 0 until the first IDLE cycle, then becomes 1. The next transfer goes to vsd_*, and vsd_miso reaches m0_miso.
- With ACT_TIMEOUT = 16, toggle mosi once → act_sd = 1 for exactly 16 cycles, then 0. A second toggle mid-window restarts the 16 cycles.
- Assert reset while m1 is granted with cs = 0 → gnt = 0, sd_cs = vsd_ss = 1, ck = 0, busy = 0 with no clock edge required.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and SPI idle levels for the SD-card SPI arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT0    = 2'd1,
    GNT1    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic CK_IDLE   = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;
  localparam logic MISO_IDLE = 1'b1;

endpackage

// File: rtl/sd_spi_arbiter_if.sv
// Requester-side (req/gnt + SPI) and target-side (plain SPI) bundles for the SD arbiter.
interface sd_spi_arbiter_if;
  logic req;
  logic gnt;
  logic ck;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output req, ck, cs, mosi, input gnt, miso);
  modport slave  (input req, ck, cs, mosi, output gnt, miso);
endinterface

interface sd_spi_target_if;
  logic ck;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output ck, cs, mosi, input miso);
  modport slave  (input ck, cs, mosi, output miso);
endinterface

// File: rtl/sd_activity_timer.sv
// Flags SD activity for ACT_TIMEOUT cycles after any mosi/miso change on the active path.
module sd_activity_timer #(
  parameter int ACT_TIMEOUT = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_mosi,
  input  logic i_miso,
  output logic o_act
);
  localparam int CW = $clog2(ACT_TIMEOUT + 1);

  logic          r_prev_mosi;
  logic          r_prev_miso;
  logic [CW-1:0] r_cnt;
  logic          w_change;

  assign w_change = (i_mosi != r_prev_mosi) || (i_miso != r_prev_miso);

  // Counter parks at ACT_TIMEOUT so the flag is clear out of reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_prev_mosi <= 1'b1;
      r_prev_miso <= 1'b1;
      r_cnt       <= CW'(ACT_TIMEOUT);
    end else begin
      r_prev_mosi <= i_mosi;
      r_prev_miso <= i_miso;
      if (w_change)
        r_cnt <= '0;
      else if (r_cnt != CW'(ACT_TIMEOUT))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_act = (r_cnt < CW'(ACT_TIMEOUT));

endmodule

// File: rtl/sd_spi_arbiter.sv
// Two-master SD SPI arbiter with virtual/physical target steering and activity LEDs.
// Optional activity counter is compiled in when SD_ARB_ACTIVITY_EN is defined.
module sd_spi_arbiter
  import sd_arb_pkg::*;
#(
  parameter int ACT_TIMEOUT = 1000000,
  parameter int GUARD       = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_img_mounted,
  input  logic                   i_img_present,
  sd_spi_arbiter_if.slave        m0,
  sd_spi_arbiter_if.slave        m1,
  sd_spi_target_if.master        vsd,
  sd_spi_target_if.master        sd,
  output logic                   o_vsd_sel,
  output logic                   o_act_vsd,
  output logic                   o_act_sd,
  output logic                   o_busy
);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  arb_state_e    r_state, w_next;
  logic          r_last1, w_next_last1;
  logic [GW-1:0] r_guard_cnt;
  logic          r_pending;
  logic          r_vsd_sel;
  logic          w_gnt0, w_gnt1;
  logic          w_ck, w_cs, w_mosi, w_tgt_miso;

  // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_last1     <= 1'b1;
      r_guard_cnt <= '0;
      r_pending   <= 1'b0;
      r_vsd_sel   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_last1     <= w_next_last1;
      r_guard_cnt <= (r_state == RELEASE) ? r_guard_cnt + GW'(1) : '0;
      if (i_img_mounted)
        r_pending <= i_img_present;
      if (r_state == IDLE)
        r_vsd_sel <= r_pending;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (latch).
  always_comb begin
    w_next       = r_state;
    w_next_last1 = r_last1;
    case (r_state)
      IDLE: begin
        // r_last1 = 1 means m1 won last, so m0 takes a tie.
        if (m0.req && (!m1.req || r_last1)) begin
          w_next       = GNT0;
          w_next_last1 = 1'b0;
        end else if (m1.req) begin
          w_next       = GNT1;
          w_next_last1 = 1'b1;
        end
      end
      GNT0:    if (!m0.req && m0.cs) w_next = RELEASE;
      GNT1:    if (!m1.req && m1.cs) w_next = RELEASE;
      RELEASE: if (r_guard_cnt == GW'(GUARD - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);

  always_comb begin
    w_ck   = CK_IDLE;
    w_cs   = CS_IDLE;
    w_mosi = MOSI_IDLE;
    if (w_gnt0) begin
      w_ck   = m0.ck;
      w_cs   = m0.cs;
      w_mosi = m0.mosi;
    end else if (w_gnt1) begin
      w_ck   = m1.ck;
      w_cs   = m1.cs;
      w_mosi = m1.mosi;
    end
  end

  assign vsd.ck   = r_vsd_sel ? w_ck   : CK_IDLE;
  assign vsd.cs   = r_vsd_sel ? w_cs   : CS_IDLE;
  assign vsd.mosi = r_vsd_sel ? w_mosi : MOSI_IDLE;
  assign sd.ck    = r_vsd_sel ? CK_IDLE   : w_ck;
  assign sd.cs    = r_vsd_sel ? CS_IDLE   : w_cs;
  assign sd.mosi  = r_vsd_sel ? MOSI_IDLE : w_mosi;

  assign w_tgt_miso = r_vsd_sel ? vsd.miso : sd.miso;
  assign m0.miso    = w_gnt0 ? w_tgt_miso : MISO_IDLE;
  assign m1.miso    = w_gnt1 ? w_tgt_miso : MISO_IDLE;
  assign m0.gnt     = w_gnt0;
  assign m1.gnt     = w_gnt1;

  assign o_vsd_sel = r_vsd_sel;
  assign o_busy    = (r_state != IDLE);

`ifdef SD_ARB_ACTIVITY_EN
  logic w_act;

  sd_activity_timer #(.ACT_TIMEOUT(ACT_TIMEOUT)) u_activity (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_mosi  (w_mosi),
    .i_miso  (w_tgt_miso),
    .o_act   (w_act)
  );

  assign o_act_vsd = w_act & r_vsd_sel;
  assign o_act_sd  = w_act & ~r_vsd_sel;
`else
  assign o_act_vsd = 1'b0;
  assign o_act_sd  = 1'b0;
`endif

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Bench for sd_spi_arbiter: behavioural model checked every cycle plus directed literal checks.
module tb_sd_spi_arbiter;
  localparam int ACT_TIMEOUT = 16;
  localparam int GUARD       = 4;
`ifdef SD_ARB_ACTIVITY_EN
  localparam bit ACT_EN = 1'b1;
`else
  localparam bit ACT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic img_mounted = 1'b0;
  logic img_present = 1'b0;
  logic vsd_sel, act_vsd, act_sd, busy;

  sd_spi_arbiter_if m0_if ();
  sd_spi_arbiter_if m1_if ();
  sd_spi_target_if  vsd_if ();
  sd_spi_target_if  sd_if ();

  sd_spi_arbiter #(.ACT_TIMEOUT(ACT_TIMEOUT), .GUARD(GUARD)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_img_mounted (img_mounted),
    .i_img_present (img_present),
    .m0            (m0_if),
    .m1            (m1_if),
    .vsd           (vsd_if),
    .sd            (sd_if),
    .o_vsd_sel     (vsd_sel),
    .o_act_vsd     (act_vsd),
    .o_act_sd      (act_sd),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, how many guard cycles remain, and when the path last changed.
  int m_owner   = -1;
  int m_cool    = 0;
  bit m_last1   = 1'b1;
  bit m_pend    = 1'b0;
  bit m_vsel    = 1'b0;
  int m_ec      = 0;
  int m_lastchg = -1000;
  bit m_pmo     = 1'b1;
  bit m_pmi     = 1'b1;

  function automatic bit mdl_ck();
    return (m_owner == 0) ? m0_if.ck : (m_owner == 1) ? m1_if.ck : 1'b0;
  endfunction
  function automatic bit mdl_cs();
    return (m_owner == 0) ? m0_if.cs : (m_owner == 1) ? m1_if.cs : 1'b1;
  endfunction
  function automatic bit mdl_mosi();
    return (m_owner == 0) ? m0_if.mosi : (m_owner == 1) ? m1_if.mosi : 1'b1;
  endfunction
  function automatic bit mdl_tmiso();
    return m_vsel ? vsd_if.miso : sd_if.miso;
  endfunction

  always @(negedge rst_n) begin
    m_owner = -1; m_cool = 0; m_last1 = 1'b1; m_pend = 1'b0; m_vsel = 1'b0;
    m_lastchg = m_ec - 1000; m_pmo = 1'b1; m_pmi = 1'b1;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit mo, mi, idle, pend_nx, oreq, ocs;
      mo = mdl_mosi();
      mi = mdl_tmiso();
      m_ec++;
      if (mo !== m_pmo || mi !== m_pmi) m_lastchg = m_ec;
      m_pmo = mo;
      m_pmi = mi;
      idle    = (m_owner < 0) && (m_cool == 0);
      pend_nx = img_mounted ? img_present : m_pend;
      if (idle) begin
        m_vsel = m_pend;
        if (m0_if.req && m1_if.req) m_owner = m_last1 ? 0 : 1;
        else if (m0_if.req)         m_owner = 0;
        else if (m1_if.req)         m_owner = 1;
        if (m_owner >= 0) m_last1 = (m_owner == 1);
      end else if (m_owner >= 0) begin
        oreq = (m_owner == 0) ? m0_if.req : m1_if.req;
        ocs  = (m_owner == 0) ? m0_if.cs  : m1_if.cs;
        if (!oreq && ocs) begin
          m_owner = -1;
          m_cool  = GUARD;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end
      m_pend = pend_nx;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit ia, tm;
      ia = ACT_EN && ((m_ec - m_lastchg) < ACT_TIMEOUT);
      tm = mdl_tmiso();
      check("m0_gnt",   m0_if.gnt,   m_owner == 0);
      check("m1_gnt",   m1_if.gnt,   m_owner == 1);
      check("busy",     busy,        (m_owner >= 0) || (m_cool > 0));
      check("vsd_sel",  vsd_sel,     m_vsel);
      check("vsd_ck",   vsd_if.ck,   m_vsel ? mdl_ck()   : 1'b0);
      check("vsd_ss",   vsd_if.cs,   m_vsel ? mdl_cs()   : 1'b1);
      check("vsd_mosi", vsd_if.mosi, m_vsel ? mdl_mosi() : 1'b1);
      check("sd_ck",    sd_if.ck,    m_vsel ? 1'b0 : mdl_ck());
      check("sd_cs",    sd_if.cs,    m_vsel ? 1'b1 : mdl_cs());
      check("sd_mosi",  sd_if.mosi,  m_vsel ? 1'b1 : mdl_mosi());
      check("m0_miso",  m0_if.miso,  (m_owner == 0) ? tm : 1'b1);
      check("m1_miso",  m1_if.miso,  (m_owner == 1) ? tm : 1'b1);
      check("act_vsd",  act_vsd,     ia & m_vsel);
      check("act_sd",   act_sd,      ia & ~m_vsel);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_act(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (act_sd) cnt++;
      else break;
    end
  endtask

  initial begin
    int lat, cnt;
    m0_if.req = 0; m0_if.ck = 0; m0_if.cs = 1; m0_if.mosi = 1;
    m1_if.req = 0; m1_if.ck = 0; m1_if.cs = 1; m1_if.mosi = 1;
    vsd_if.miso = 1; sd_if.miso = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_m0_gnt", m0_if.gnt, 0);
    check("rst_vsd_sel", vsd_sel, 0);
    check("rst_m0_miso", m0_if.miso, 1);
    check("rst_sd_cs", sd_if.cs, 1);
    check("rst_act_sd", act_sd, 0);
    rst_n = 1;

    // Single request goes to the physical card.
    m0_if.req = 1;
    tick(1);
    check("t1_m0_gnt", m0_if.gnt, 1);
    m0_if.cs = 0; m0_if.ck = 1; m0_if.mosi = 0; sd_if.miso = 0;
    #1;
    check("t1_sd_ck", sd_if.ck, 1);
    check("t1_sd_cs", sd_if.cs, 0);
    check("t1_sd_mosi", sd_if.mosi, 0);
    check("t1_vsd_ss", vsd_if.cs, 1);
    check("t1_m1_miso", m1_if.miso, 1);
    check("t1_m0_miso", m0_if.miso, 0);
    tick(2);
    m0_if.cs = 1; m0_if.ck = 0; m0_if.mosi = 1; m0_if.req = 0; sd_if.miso = 1;
    tick(1);
    check("t1_release", m0_if.gnt, 0);
    tick(4);

    // Tie after reset: m0 first, m1 GUARD+1 cycles after m0 drops.
    rst_n = 0;
    #2;
    rst_n = 1;
    m0_if.req = 1; m1_if.req = 1;
    tick(1);
    check("t2_m0_gnt", m0_if.gnt, 1);
    check("t2_m1_gnt", m1_if.gnt, 0);
    m0_if.req = 0;
    tick(1);
    check("t2_m0_drop", m0_if.gnt, 0);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (m1_if.gnt) begin
        lat = i;
        break;
      end
    end
    check("t2_m1_latency", lat, GUARD + 1);
    m1_if.req = 0;
    tick(6);

    // Grant held while cs stays low.
    m0_if.req = 1;
    tick(1);
    m0_if.cs = 0; m0_if.req = 0;
    tick(3);
    check("t3_hold", m0_if.gnt, 1);
    m0_if.cs = 1;
    #1;
    check("t3_hold_noedge", m0_if.gnt, 1);
    tick(1);
    check("t3_drop", m0_if.gnt, 0);
    tick(5);

    // Mount during a grant switches to the virtual card after release.
    m0_if.req = 1;
    tick(1);
    m0_if.cs = 0;
    img_present = 1; img_mounted = 1;
    tick(1);
    img_mounted = 0;
    tick(2);
    check("t4_sel_held", vsd_sel, 0);
    m0_if.cs = 1; m0_if.req = 0;
    tick(1);
    tick(4);
    check("t4_sel_first_idle", vsd_sel, 0);
    tick(1);
    check("t4_sel_switched", vsd_sel, 1);
    m0_if.req = 1;
    tick(1);
    m0_if.cs = 0; m0_if.ck = 1; m0_if.mosi = 0; vsd_if.miso = 0;
    #1;
    check("t4_vsd_ss", vsd_if.cs, 0);
    check("t4_vsd_ck", vsd_if.ck, 1);
    check("t4_sd_cs", sd_if.cs, 1);
    check("t4_m0_miso", m0_if.miso, 0);
    tick(2);
    m0_if.cs = 1; m0_if.ck = 0; m0_if.mosi = 1; m0_if.req = 0; vsd_if.miso = 1;
    tick(6);

    // Activity window on the physical card.
    img_present = 0; img_mounted = 1;
    tick(1);
    img_mounted = 0;
    tick(2);
    tick(20);
    check("t5_act_quiet", act_sd, 0);
    check("t5_sel_phys", vsd_sel, 0);
    m0_if.req = 1;
    tick(1);
    m0_if.cs = 0;
    m0_if.mosi = 0;
    count_act(cnt);
    check("t5_window", cnt, ACT_EN ? ACT_TIMEOUT : 0);
    m0_if.mosi = 1;
    tick(8);
    m0_if.mosi = 0;
    count_act(cnt);
    check("t5_restart", cnt, ACT_EN ? ACT_TIMEOUT : 0);
    m0_if.cs = 1; m0_if.req = 0; m0_if.mosi = 1;
    tick(6);

    // Asynchronous reset mid-transfer.
    m1_if.req = 1;
    tick(1);
    m1_if.cs = 0; m1_if.ck = 1;
    #1;
    check("t6_sd_cs_active", sd_if.cs, 0);
    rst_n = 0;
    #1;
    check("t6_m1_gnt", m1_if.gnt, 0);
    check("t6_sd_cs", sd_if.cs, 1);
    check("t6_vsd_ss", vsd_if.cs, 1);
    check("t6_sd_ck", sd_if.ck, 0);
    check("t6_busy", busy, 0);
    check("t6_m1_miso", m1_if.miso, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
